// File: rtl/stream_rd_pkg.sv
// Shared types and helpers for the round-robin stream instruction reader.
// Combinational definitions only: no latency, no backpressure.
package stream_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } rd_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_LEN_W  = 4;

    function automatic int ch_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or after ptr, combinational grant, ptr moves past winner on accept.
// Latency 0 (grant same cycle); holds pointer while advance_i is low.
module rr_arbiter
    import stream_rd_pkg::*;
#(
    parameter int  NUM_CH = 5,
    localparam int ID_W   = ch_id_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              advance_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [ID_W-1:0]   gnt_id_o,
    output logic              gnt_vld_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_CH)) begin
                sum = sum - (ID_W+1)'(NUM_CH);
            end
            idx = sum[ID_W-1:0];
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o  = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && gnt_vld_o) begin
            ptr_d = (gnt_id_o == ID_W'(NUM_CH-1)) ? '0 : gnt_id_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_inst_reader_rr.sv
// Arbitrates NUM_CH burst requesters onto one BRAM read port, one read outstanding; accept->rd_start 1 cycle.
// Response beats hold until the granted channel's rsp_ready; STREAM_RD_TIMEOUT_EN adds a WAIT-state timeout.
module stream_inst_reader_rr
    import stream_rd_pkg::*;
#(
    parameter int NUM_CH      = 5,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int ADDR_STEP   = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*LEN_W-1:0]    req_len,
    output logic [NUM_CH-1:0]          rsp_valid,
    input  logic [NUM_CH-1:0]          rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_last,
    output logic                       rsp_err,
    output logic                       rd_start,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic [DATA_W-1:0]          rd_data,
    input  logic                       rd_done,
    output logic                       busy,
    output logic [ch_id_w(NUM_CH)-1:0] grant_id
);

    localparam int ID_W = ch_id_w(NUM_CH);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [NUM_CH-1:0] arb_gnt;
    logic [ID_W-1:0]   arb_id;
    logic              arb_vld;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic              handshake;
    logic              is_last;
    logic              timeout;
    logic              err_q;

    assign accept = (state_q == ST_IDLE) && arb_vld && !rst;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .advance_i (accept),
        .gnt_o     (arb_gnt),
        .gnt_id_o  (arb_id),
        .gnt_vld_o (arb_vld)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign handshake = rsp_ready[gid_q];
    assign is_last   = (beat_q == len_q);

`ifdef STREAM_RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_d;

    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        case (state_q)
            ST_ISSUE: begin
                to_cnt_d = '0;
                err_d    = 1'b0;
            end
            ST_WAIT: begin
                if (!rd_done && timeout) begin
                    err_d = 1'b1;
                end else if (!rd_done) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
    assign timeout            = 1'b0;
    assign err_q              = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        gid_d     = gid_q;
        data_d    = data_q;
        req_ready = '0;
        rd_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready = arb_gnt;
                    addr_d    = sel_addr;
                    len_d     = sel_len;
                    gid_d     = arb_id;
                    beat_d    = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_start = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (rd_done) begin
                    data_d  = rd_data;
                    state_d = ST_RESP;
                end else if (timeout) begin
                    data_d  = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // A timed-out beat always ends the burst.
                if (handshake) begin
                    if (is_last || err_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(ADDR_STEP);
                        beat_d  = beat_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            gid_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP) ? (NUM_CH'(1) << gid_q) : '0;
    assign rsp_data  = data_q;
    assign rsp_last  = (state_q == ST_RESP) && (is_last || err_q);
    assign rsp_err   = (state_q == ST_RESP) && err_q;
    assign rd_addr   = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = gid_q;

endmodule

// File: tb/tb_stream_inst_reader_rr.sv
// Directed bench for stream_inst_reader_rr: vector table of bursts plus hand sequences for
// reset, round robin, backpressure, address wrap and stray completions.
module tb_stream_inst_reader_rr;

    localparam int NUM_CH = 5;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int LEN_W  = 4;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*LEN_W-1:0]  req_len;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [NUM_CH-1:0]        rsp_ready;
    logic [DATA_W-1:0]        rsp_data;
    logic                     rsp_last;
    logic                     rsp_err;
    logic                     rd_start;
    logic [ADDR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_done;
    logic                     busy;
    logic [2:0]               grant_id;

    int errors = 0;
    int checks = 0;

    stream_inst_reader_rr #(
        .NUM_CH      (NUM_CH),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .LEN_W       (LEN_W),
        .ADDR_STEP   (1),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .rd_start  (rd_start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_done   (rd_done),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [127:0] data;
        int          dly;
        logic [31:0] exp_addr0;
        logic [31:0] exp_addr_last;
        int          exp_beats;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] all_out();
        return {req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, rd_start, rd_addr, busy, grant_id};
    endfunction

    task automatic set_req(input int ch, input logic [31:0] addr, input logic [3:0] len);
        req_addr[ch*ADDR_W +: ADDR_W] = addr;
        req_len[ch*LEN_W +: LEN_W]    = len;
    endtask

    task automatic run_burst(input vec_t v);
        logic [31:0]  ea;
        logic [127:0] ed;
        logic [4:0]   oh;
        oh        = '0;
        oh[v.ch]  = 1'b1;
        set_req(v.ch, v.addr, v.len);
        req_valid = oh;
        #1;
        chk("req_ready", req_ready, oh);
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < v.exp_beats; k++) begin
            ea = v.exp_addr0 + 32'(k);
            ed = v.data ^ 128'(k);
            chk("rd_start", rd_start, 1);
            chk("rd_addr", rd_addr, ea);
            if (k == v.exp_beats - 1) chk("rd_addr_last", rd_addr, v.exp_addr_last);
            @(negedge clk);
            repeat (v.dly) begin
                chk("wait_quiet", {rsp_valid, rd_start}, 0);
                @(negedge clk);
            end
            rd_done = 1'b1;
            rd_data = ed;
            @(negedge clk);
            rd_done = 1'b0;
            rd_data = '0;
            chk("rsp_valid", rsp_valid, oh);
            chk("rsp_data", rsp_data, ed);
            chk("rsp_last", rsp_last, (k == v.exp_beats - 1));
            chk("rsp_err", rsp_err, 0);
            chk("grant_id", grant_id, v.ch);
            rsp_ready = oh;
            @(negedge clk);
            rsp_ready = '0;
        end
        chk("idle_busy", busy, 0);
        chk("idle_grant_id", grant_id, v.ch);
    endtask

    initial begin
        int          order[6];
        logic [4:0]  oh;
        logic [127:0] bp_data;

        vecs[0] = '{2, 32'h40,        4'd0, {4{32'hA5A5_A5A5}}, 2, 32'h40,        32'h40,  1};
        vecs[1] = '{0, 32'h100,       4'd3, {4{32'h1234_5678}}, 0, 32'h100,       32'h103, 4};
        vecs[2] = '{4, 32'hFFFF_FFFF, 4'd1, {4{32'hC0DE_0004}}, 1, 32'hFFFF_FFFF, 32'h0,   2};
        vecs[3] = '{1, 32'h7FE,       4'd2, {4{32'h0BAD_F00D}}, 4, 32'h7FE,       32'h800, 3};
        order   = '{0, 1, 4, 0, 1, 4};

        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        rsp_ready = '0;
        rd_data   = '0;
        rd_done   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", all_out(), 0);

        for (int i = 0; i < 4; i++) begin
            run_burst(vecs[i]);
        end

        // Reset while a read is outstanding, then a late completion.
        set_req(1, 32'h55, 4'd0);
        req_valid = 5'b00010;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("wait_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_wait", all_out(), 0);
        rst     = 1'b0;
        rd_done = 1'b1;
        rd_data = {4{32'hDEAD_0001}};
        @(negedge clk);
        rd_done = 1'b0;
        chk("late_done_ignored", {rsp_valid, busy, rsp_data != 0}, 0);
        @(negedge clk);
        chk("late_done_still_idle", all_out(), 0);

        // Round robin with channels 0, 1 and 4 held valid.
        for (int c = 0; c < NUM_CH; c++) set_req(c, 32'h200 + 32'(c), 4'd0);
        req_valid = 5'b10011;
        for (int i = 0; i < 6; i++) begin
            oh = 5'(1) << order[i];
            #1;
            chk("rr_grant", req_ready, oh);
            @(negedge clk);
            chk("rr_rd_addr", rd_addr, 32'h200 + 32'(order[i]));
            chk("rr_no_accept_busy", req_ready, 0);
            @(negedge clk);
            rd_done = 1'b1;
            rd_data = 128'(i);
            @(negedge clk);
            rd_done = 1'b0;
            chk("rr_rsp_valid", rsp_valid, oh);
            rsp_ready = oh;
            @(negedge clk);
            rsp_ready = '0;
        end
        req_valid = '0;

        // Backpressure on channel 3 with every other rsp_ready high.
        bp_data = {4{32'hBEEF_0303}};
        set_req(3, 32'h300, 4'd0);
        req_valid = 5'b01000;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rd_done = 1'b1;
        rd_data = bp_data;
        @(negedge clk);
        rd_done   = 1'b0;
        rd_data   = '0;
        rsp_ready = 5'b10111;
        repeat (5) begin
            chk("bp_hold", {rsp_valid, rsp_data, rsp_last, rd_start}, {5'b01000, bp_data, 1'b1, 1'b0});
            @(negedge clk);
        end
        chk("bp_still_valid", rsp_valid, 5'b01000);
        rsp_ready = 5'b01000;
        @(negedge clk);
        rsp_ready = '0;
        chk("bp_done_idle", {busy, rsp_valid}, 0);
        chk("bp_grant_hold", grant_id, 3);

        // Stray completion while idle.
        rd_done = 1'b1;
        rd_data = {4{32'h5757_5757}};
        @(negedge clk);
        rd_done = 1'b0;
        chk("stray_no_rsp", {rsp_valid, busy, rd_start}, 0);
        chk("stray_data_kept", rsp_data, bp_data);

`ifdef STREAM_RD_TIMEOUT_EN
        set_req(2, 32'h80, 4'd3);
        req_valid = 5'b00100;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        repeat (7) begin
            chk("to_wait_quiet", rsp_valid, 0);
            @(negedge clk);
        end
        chk("to_wait8_quiet", rsp_valid, 0);
        @(negedge clk);
        chk("to_rsp", {rsp_valid, rsp_err, rsp_last, rsp_data}, {5'b00100, 1'b1, 1'b1, 128'h0});
        rsp_ready = 5'b00100;
        @(negedge clk);
        rsp_ready = '0;
        chk("to_aborted", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_inst_reader_rr.md
Name: stream_inst_reader_rr

Overview:
- Clocked, parametrised successor of the five-channel stream instruction reader: arbitrates NUM_CH requesters onto one BRAM read port.
- Adds per-request bursts (base address + beat count, auto-incrementing address), round-robin fairness and per-beat response backpressure.
- Sits between the instruction-stream consumers and the instruction BRAM read interface.
- One read outstanding at a time.

Parameters:
- NUM_CH, 5, number of requesting channels (2..16).
- ADDR_W, 32, BRAM address width.
- DATA_W, 128, read data width.
- LEN_W, 4, width of burst length field; burst beats = req_len+1.
- ADDR_STEP, 1, address increment per beat.
- TIMEOUT_CYC, 255, WAIT-state cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel request accept (one-hot pulse)
- req_addr  in  NUM_CH*ADDR_W  per-channel base address, channel i at [i*ADDR_W +: ADDR_W]
- req_len  in  NUM_CH*LEN_W  per-channel beats minus one
- rsp_valid  out  NUM_CH  one-hot response valid
- rsp_ready  in  NUM_CH  per-channel response accept
- rsp_data  out  DATA_W  shared response data
- rsp_last  out  1  final beat of burst
- rsp_err  out  1  beat aborted by timeout
- rd_start  out  1  BRAM read strobe, one-cycle pulse
- rd_addr  out  ADDR_W  BRAM read address
- rd_data  in  DATA_W  BRAM read data, valid with rd_done
- rd_done  in  1  BRAM read completion pulse
- busy  out  1  high when FSM not in IDLE
- grant_id  out  $clog2(NUM_CH)  currently granted channel

Behaviour:
- Reset: all outputs 0, FSM IDLE, round-robin pointer 0, data/addr/beat registers 0. Reset mid-burst aborts immediately; no response is produced for the in-flight beat, and a late rd_done after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first asserted channel at or after the pointer (wrapping).
  - Same cycle: req_ready[g]=1; latch req_addr, req_len and g; set beat counter=0. Next state ISSUE.
  - Pointer becomes (g+1) mod NUM_CH on grant.
- ISSUE: rd_start=1 for exactly one cycle; rd_addr = latched address, held stable until the next ISSUE. Next state WAIT.
- WAIT:
  - On rd_done, capture rd_data into rsp_data. Next state RESP.
  - rd_done in any other state is ignored.
- RESP:
  - rsp_valid[g]=1; rsp_data stable; rsp_last=1 iff beat counter == latched len.
  - Hold until rsp_ready[g]; the rsp_ready of other channels is ignored.
  - On handshake with last: go to IDLE, where arbitration may grant in that same IDLE cycle.
  - On handshake without last: address += ADDR_STEP (modulo 2^ADDR_W, wraps silently), beat counter +1, go to ISSUE.
- Latency: request accept to rd_start = 1 cycle; rd_done to rsp_valid = 1 cycle; rsp handshake to next rd_start = 1 cycle.
- req_valid changes during a burst do not affect it; requests are not queued, so the channel holds req_valid until req_ready.
- grant_id holds the last grant while in IDLE.
- rsp_err = 0 unless the optional feature fires.

Optional Feature:
- STREAM_RD_TIMEOUT_EN defined:
  - WAIT counts cycles; at TIMEOUT_CYC cycles without rd_done, enter RESP with rsp_data=0, rsp_err=1, rsp_last=1; the burst is aborted after the handshake.
  - Counter clears on entry to WAIT.
- Undefined: WAIT waits indefinitely, no counter logic is generated, and rsp_err is tied 0.

Decomposition:
- Shared package stream_rd_pkg holds:
  - FSM state enum (IDLE/ISSUE/WAIT/RESP).
  - Default widths for ADDR/DATA/LEN.
  - Function for the channel id width.
- One sub-module: rr_arbiter (NUM_CH request vector, pointer register, one-hot grant plus encoded id, advance-on-accept input).

Test Plan:
- Single beat: ch2 req addr=0x40 len=0; rd_done 3 cycles after rd_start with data=0xA5.. -> rd_addr=0x40, rsp_valid=0b00100, rsp_last=1, rsp_data=0xA5..
- Burst: ch0 addr=0x100 len=3 -> rd_addr sequence 0x100,0x101,0x102,0x103; rsp_last only on the 4th beat.
- Round robin: ch0, ch1 and ch4 held valid continuously -> grant order 0,1,4,0,1,4; no channel is granted twice while another waits.
- Backpressure: rsp_ready[g] low for 5 cycles -> rsp_valid and rsp_data stable, no rd_start issued.
- Wrap and stray done: addr=0xFFFF_FFFF len=1 -> second rd_addr=0x0; an rd_done pulse in IDLE produces no response.
- Reset/timeout: rst asserted in WAIT -> all outputs 0 next cycle. With STREAM_RD_TIMEOUT_EN and TIMEOUT_CYC=8, no rd_done -> rsp_err=1, rsp_data=0 on the 9th WAIT cycle.
